// File: rtl/cheri_pkg.sv
// Shared types for the stack-zeroizer / core LSU arbiter: owner tags, FSM states, fairness limit.
package cheri_pkg;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_STKZ = 1'b1
    } arb_owner_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_CORE = 2'd1,
        ARB_STKZ = 2'd2
    } arb_state_t;

    // Consecutive core grants tolerated while the zeroizer waits, when fairness is built.
    localparam int unsigned ARB_FAIR_LIMIT = 7;

    function automatic arb_state_t owner_state(arb_owner_t owner);
        return (owner == OWN_STKZ) ? ARB_STKZ : ARB_CORE;
    endfunction

endpackage

// File: rtl/cheri_stkz_lsu_arb_if.sv
// Bundle of core, zeroizer and LSU request/response signals around the arbiter.
// slave = arbiter side, master = requesters plus LSU.
interface cheri_stkz_lsu_arb_if #(
    parameter int unsigned DataWidth = 33
);
    logic                 core_req_i;
    logic                 core_we_i;
    logic                 core_is_cap_i;
    logic [31:0]          core_addr_i;
    logic [DataWidth-1:0] core_wdata_i;
    logic                 core_req_done_o;
    logic                 core_resp_valid_o;
    logic                 core_resp_err_o;

    logic                 stkz_req_i;
    logic                 stkz_we_i;
    logic                 stkz_is_cap_i;
    logic [31:0]          stkz_addr_i;
    logic [DataWidth-1:0] stkz_wdata_i;
    logic                 stkz_req_done_o;
    logic                 stkz_resp_valid_o;
    logic                 stkz_resp_err_o;

    logic                 lsu_req_o;
    logic                 lsu_we_o;
    logic                 lsu_is_cap_o;
    logic [31:0]          lsu_addr_o;
    logic [DataWidth-1:0] lsu_wdata_o;
    logic                 lsu_req_done_i;
    logic                 lsu_resp_valid_i;
    logic                 lsu_resp_err_i;

    modport slave (
        input  core_req_i, core_we_i, core_is_cap_i, core_addr_i, core_wdata_i,
        output core_req_done_o, core_resp_valid_o, core_resp_err_o,
        input  stkz_req_i, stkz_we_i, stkz_is_cap_i, stkz_addr_i, stkz_wdata_i,
        output stkz_req_done_o, stkz_resp_valid_o, stkz_resp_err_o,
        output lsu_req_o, lsu_we_o, lsu_is_cap_o, lsu_addr_o, lsu_wdata_o,
        input  lsu_req_done_i, lsu_resp_valid_i, lsu_resp_err_i
    );

    modport master (
        output core_req_i, core_we_i, core_is_cap_i, core_addr_i, core_wdata_i,
        input  core_req_done_o, core_resp_valid_o, core_resp_err_o,
        output stkz_req_i, stkz_we_i, stkz_is_cap_i, stkz_addr_i, stkz_wdata_i,
        input  stkz_req_done_o, stkz_resp_valid_o, stkz_resp_err_o,
        input  lsu_req_o, lsu_we_o, lsu_is_cap_o, lsu_addr_o, lsu_wdata_o,
        output lsu_req_done_i, lsu_resp_valid_i, lsu_resp_err_i
    );

endinterface

// File: rtl/cheri_lsu_owner_fifo.sv
// Two-entry FIFO of request owners awaiting an LSU response; head bypasses the push when empty.
// Zero-latency head; no internal backpressure, the caller stops granting while full.
module cheri_lsu_owner_fifo
    import cheri_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  arb_owner_t push_owner_i,
    input  logic       pop_i,
    output arb_owner_t head_o,
    output logic [1:0] count_o
);

    arb_owner_t mem_q [2];
    logic       wr_ptr_q, rd_ptr_q;
    logic [1:0] count_q;
    logic       empty, bypass, do_push, do_pop;

    assign empty   = (count_q == 2'd0);
    // A push popped in the same cycle on an empty FIFO never gets stored.
    assign bypass  = push_i && pop_i && empty;
    assign do_push = push_i && !bypass;
    assign do_pop  = pop_i && !empty;
    assign head_o  = empty ? push_owner_i : mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q[0] <= OWN_CORE;
            mem_q[1] <= OWN_CORE;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_owner_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (do_push && count_q == 2'd2) |-> do_pop);
`endif

endmodule

// File: rtl/cheri_stkz_lsu_arb.sv
// Merges core and stack-zeroizer LSU traffic; holds the owner until done, routes responses via an owner FIFO.
// Zero-latency grant; no grant while two responses are outstanding. CHERI_STKZ_ARB_FAIR_EN adds zeroizer fairness.
module cheri_stkz_lsu_arb
    import cheri_pkg::*;
#(
    parameter int unsigned DataWidth = 33
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    cheri_stkz_lsu_arb_if.slave  bus
);

    arb_state_t           state_q, state_d;
    arb_owner_t           pick, owner, fifo_head;
    logic                 pick_vld, own_vld, fair_force, stall;
    logic                 lsu_req, push, resp_ok;
    logic [1:0]           fifo_cnt;
    logic [DataWidth-1:0] wdata_mux;

    assign stall = (fifo_cnt == 2'd2) && !bus.lsu_resp_valid_i;

    always_comb begin
        pick     = OWN_CORE;
        pick_vld = 1'b0;
        if (!stall) begin
            if (bus.stkz_req_i && (fair_force || !bus.core_req_i)) begin
                pick     = OWN_STKZ;
                pick_vld = 1'b1;
            end else if (bus.core_req_i) begin
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        owner   = pick;
        own_vld = pick_vld;
        unique case (state_q)
            ARB_CORE: begin owner = OWN_CORE; own_vld = 1'b1; end
            ARB_STKZ: begin owner = OWN_STKZ; own_vld = 1'b1; end
            default:  ;
        endcase
    end

    always_comb begin
        lsu_req          = 1'b0;
        bus.lsu_we_o     = 1'b0;
        bus.lsu_is_cap_o = 1'b0;
        bus.lsu_addr_o   = '0;
        wdata_mux        = '0;
        if (own_vld) begin
            if (owner == OWN_STKZ) begin
                lsu_req          = bus.stkz_req_i;
                bus.lsu_we_o     = bus.stkz_we_i;
                bus.lsu_is_cap_o = bus.stkz_is_cap_i;
                bus.lsu_addr_o   = bus.stkz_addr_i;
                wdata_mux        = bus.stkz_wdata_i;
            end else begin
                lsu_req          = bus.core_req_i;
                bus.lsu_we_o     = bus.core_we_i;
                bus.lsu_is_cap_o = bus.core_is_cap_i;
                bus.lsu_addr_o   = bus.core_addr_i;
                wdata_mux        = bus.core_wdata_i;
            end
        end
    end

    assign bus.lsu_req_o   = lsu_req;
    assign bus.lsu_wdata_o = wdata_mux;

    // A done in the grant cycle completes the request without leaving idle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE: if (lsu_req && !bus.lsu_req_done_i) state_d = owner_state(owner);
            ARB_CORE,
            ARB_STKZ: if (bus.lsu_req_done_i) state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ARB_IDLE;
        else         state_q <= state_d;
    end

    assign push                = bus.lsu_req_done_i && own_vld;
    assign bus.core_req_done_o = push && (owner == OWN_CORE);
    assign bus.stkz_req_done_o = push && (owner == OWN_STKZ);

    cheri_lsu_owner_fifo u_owner_fifo (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .push_i       (push),
        .push_owner_i (owner),
        .pop_i        (bus.lsu_resp_valid_i),
        .head_o       (fifo_head),
        .count_o      (fifo_cnt)
    );

    // Responses with nobody waiting for them are dropped.
    assign resp_ok               = bus.lsu_resp_valid_i && ((fifo_cnt != 2'd0) || push);
    assign bus.core_resp_valid_o = resp_ok && (fifo_head == OWN_CORE);
    assign bus.core_resp_err_o   = bus.core_resp_valid_o && bus.lsu_resp_err_i;
    assign bus.stkz_resp_valid_o = resp_ok && (fifo_head == OWN_STKZ);
    assign bus.stkz_resp_err_o   = bus.stkz_resp_valid_o && bus.lsu_resp_err_i;

`ifdef CHERI_STKZ_ARB_FAIR_EN
    logic       idle_grant;
    logic [2:0] fair_cnt_q;

    assign idle_grant = (state_q == ARB_IDLE) && pick_vld;
    assign fair_force = (fair_cnt_q == 3'(ARB_FAIR_LIMIT));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fair_cnt_q <= 3'd0;
        end else if (!bus.stkz_req_i || (idle_grant && pick == OWN_STKZ)) begin
            fair_cnt_q <= 3'd0;
        end else if (idle_grant) begin
            fair_cnt_q <= fair_cnt_q + 3'd1;
        end
    end
`else
    assign fair_force = 1'b0;
`endif

`ifndef SYNTHESIS
    a_resp_has_owner: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.lsu_resp_valid_i |-> ((fifo_cnt != 2'd0) || push));
`endif

endmodule

// File: tb/tb_cheri_stkz_lsu_arb.sv
// Scoreboard bench for cheri_stkz_lsu_arb: expected response owners queued at grant, checked at response.
module tb_cheri_stkz_lsu_arb;
    import cheri_pkg::*;

    localparam int unsigned DW = 33;
    typedef struct packed { logic stkz; logic err; } exp_t;

    localparam logic [31:0]   CADDR = 32'h0000_1000;
    localparam logic [31:0]   SADDR = 32'h8000_0FF8;
    localparam logic [DW-1:0] CWD   = 33'h1_DEAD_BEEF;
    localparam logic [DW-1:0] SWD   = '0;
    // {req, we, is_cap, addr, wdata} as seen on the merged LSU port
    localparam logic [DW+34:0] CORE_BUS = {1'b1, 1'b0, 1'b0, CADDR, CWD};
    localparam logic [DW+34:0] STKZ_BUS = {1'b1, 1'b1, 1'b1, SADDR, SWD};

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    int   vecs   = 0;
    int   miscmp = 0;
    exp_t exp_q[$];

    cheri_stkz_lsu_arb_if #(.DataWidth(DW)) bus();
    cheri_stkz_lsu_arb #(.DataWidth(DW)) dut (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus));

    always #5 clk_i = ~clk_i;

    function automatic logic [DW+40:0] all_outs();
        return {bus.lsu_req_o, bus.lsu_we_o, bus.lsu_is_cap_o, bus.lsu_addr_o, bus.lsu_wdata_o,
                bus.core_req_done_o, bus.core_resp_valid_o, bus.core_resp_err_o,
                bus.stkz_req_done_o, bus.stkz_resp_valid_o, bus.stkz_resp_err_o};
    endfunction

    function automatic logic [DW+34:0] lsu_bus();
        return {bus.lsu_req_o, bus.lsu_we_o, bus.lsu_is_cap_o, bus.lsu_addr_o, bus.lsu_wdata_o};
    endfunction

    function automatic logic [3:0] resp_obs();
        return {bus.core_resp_valid_o, bus.core_resp_err_o, bus.stkz_resp_valid_o, bus.stkz_resp_err_o};
    endfunction

    function automatic logic [3:0] exp_obs(exp_t e);
        return e.stkz ? {2'b00, 1'b1, e.err} : {1'b1, e.err, 2'b00};
    endfunction

    task automatic set_in(input logic creq, input logic sreq, input logic done,
                          input logic rv, input logic rerr);
        bus.core_req_i       = creq;
        bus.stkz_req_i       = sreq;
        bus.lsu_req_done_i   = done;
        bus.lsu_resp_valid_i = rv;
        bus.lsu_resp_err_i   = rerr;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        set_in(0, 0, 0, 0, 0);
        repeat (2) @(negedge clk_i);
        #1;
        vecs++;
        if (all_outs() !== '0) begin miscmp++; $display("FAIL reset_outs: got %h want 0", all_outs()); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        vecs++;
        if (all_outs() !== '0) begin miscmp++; $display("FAIL post_reset_outs: got %h want 0", all_outs()); end
    endtask

    task automatic test_priority();
        int cd = 0, sd = 0;
        exp_t e;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_i);
            set_in(c <= 2, c <= 3, c == 2 || c == 3, c == 2 || c == 3, 1'b0);
            #1;
            if (c == 0 || c == 1) begin
                if (c == 0) exp_q.push_back('{stkz: 1'b0, err: 1'b0});
                vecs++;
                if (lsu_bus() !== CORE_BUS) begin miscmp++; $display("FAIL prio_core_c%0d: got %h want %h", c, lsu_bus(), CORE_BUS); end
            end
            if (c == 3) begin
                exp_q.push_back('{stkz: 1'b1, err: 1'b0});
                vecs++;
                if (lsu_bus() !== STKZ_BUS) begin miscmp++; $display("FAIL prio_stkz: got %h want %h", lsu_bus(), STKZ_BUS); end
            end
            if (c == 4) begin
                vecs++;
                if (bus.lsu_req_o !== 1'b0) begin miscmp++; $display("FAIL prio_idle_req: got %b want 0", bus.lsu_req_o); end
            end
            cd += int'(bus.core_req_done_o);
            sd += int'(bus.stkz_req_done_o);
            if (bus.core_resp_valid_o || bus.stkz_resp_valid_o) begin
                vecs++;
                if (exp_q.size() == 0) begin
                    miscmp++; $display("FAIL prio_resp: got %b want no response", resp_obs());
                end else begin
                    e = exp_q.pop_front();
                    if (resp_obs() !== exp_obs(e)) begin miscmp++; $display("FAIL prio_resp: got %b want %b", resp_obs(), exp_obs(e)); end
                end
            end
        end
        vecs++;
        if (cd != 1) begin miscmp++; $display("FAIL prio_core_dones: got %0d want 1", cd); end
        vecs++;
        if (sd != 1) begin miscmp++; $display("FAIL prio_stkz_dones: got %0d want 1", sd); end
        vecs++;
        if (exp_q.size() != 0) begin miscmp++; $display("FAIL prio_missing_resp: got %0d pending want 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_err_route();
        exp_t e;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            set_in(1'b0, c == 0, c == 0, c == 2, c == 2);
            #1;
            if (c == 0) begin
                exp_q.push_back('{stkz: 1'b1, err: 1'b1});
                vecs++;
                if (lsu_bus() !== STKZ_BUS) begin miscmp++; $display("FAIL err_bus: got %h want %h", lsu_bus(), STKZ_BUS); end
                vecs++;
                if ({bus.core_req_done_o, bus.stkz_req_done_o} !== 2'b01) begin
                    miscmp++; $display("FAIL err_done_route: got %b want 01", {bus.core_req_done_o, bus.stkz_req_done_o});
                end
            end
            if (c == 1) begin
                vecs++;
                if (resp_obs() !== 4'b0000) begin miscmp++; $display("FAIL err_early_resp: got %b want 0000", resp_obs()); end
            end
            if (bus.core_resp_valid_o || bus.stkz_resp_valid_o) begin
                vecs++;
                if (exp_q.size() == 0) begin
                    miscmp++; $display("FAIL err_resp: got %b want no response", resp_obs());
                end else begin
                    e = exp_q.pop_front();
                    if (resp_obs() !== exp_obs(e)) begin miscmp++; $display("FAIL err_resp: got %b want %b", resp_obs(), exp_obs(e)); end
                end
            end
        end
        vecs++;
        if (exp_q.size() != 0) begin miscmp++; $display("FAIL err_missing_resp: got %0d pending want 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_outstanding();
        exp_t e;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk_i);
            set_in(c == 0 || (c >= 2 && c <= 5), c == 1, c <= 1 || c == 5, c >= 5 && c <= 7, 1'b0);
            #1;
            if (c <= 1) begin
                exp_q.push_back('{stkz: (c == 1), err: 1'b0});
                vecs++;
                if ({bus.core_req_done_o, bus.stkz_req_done_o} !== {c == 0, c == 1}) begin
                    miscmp++; $display("FAIL out_done_c%0d: got %b want %b", c, {bus.core_req_done_o, bus.stkz_req_done_o}, {c == 0, c == 1});
                end
            end
            if (c >= 2 && c <= 4) begin
                vecs++;
                if (bus.lsu_req_o !== 1'b0) begin miscmp++; $display("FAIL out_blocked_c%0d: got %b want 0", c, bus.lsu_req_o); end
            end
            if (c == 5) begin
                exp_q.push_back('{stkz: 1'b0, err: 1'b0});
                vecs++;
                if (lsu_bus() !== CORE_BUS) begin miscmp++; $display("FAIL out_unblock: got %h want %h", lsu_bus(), CORE_BUS); end
            end
            if (bus.core_resp_valid_o || bus.stkz_resp_valid_o) begin
                vecs++;
                if (exp_q.size() == 0) begin
                    miscmp++; $display("FAIL out_resp_c%0d: got %b want no response", c, resp_obs());
                end else begin
                    e = exp_q.pop_front();
                    if (resp_obs() !== exp_obs(e)) begin miscmp++; $display("FAIL out_resp_c%0d: got %b want %b", c, resp_obs(), exp_obs(e)); end
                end
            end
        end
        vecs++;
        if (exp_q.size() != 0) begin miscmp++; $display("FAIL out_missing_resp: got %0d pending want 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_fairness();
        int   model_cnt  = 0;
        int   first_stkz = 0;
        int   want_first;
        logic exp_stkz;
        exp_t e;
        @(negedge clk_i);
        set_in(0, 0, 0, 0, 0);
`ifdef CHERI_STKZ_ARB_FAIR_EN
        want_first = 8;
`else
        want_first = 0;
`endif
        for (int s = 1; s <= 12; s++) begin
            @(negedge clk_i);
            set_in(1, 1, 1, 1, 0);
            #1;
`ifdef CHERI_STKZ_ARB_FAIR_EN
            exp_stkz  = (model_cnt == 7);
            model_cnt = exp_stkz ? 0 : model_cnt + 1;
`else
            exp_stkz  = 1'b0;
`endif
            exp_q.push_back('{stkz: exp_stkz, err: 1'b0});
            vecs++;
            if (lsu_bus() !== (exp_stkz ? STKZ_BUS : CORE_BUS)) begin
                miscmp++; $display("FAIL fair_grant_s%0d: got %h want %h", s, lsu_bus(), exp_stkz ? STKZ_BUS : CORE_BUS);
            end
            vecs++;
            if ({bus.core_req_done_o, bus.stkz_req_done_o} !== {~exp_stkz, exp_stkz}) begin
                miscmp++; $display("FAIL fair_done_s%0d: got %b want %b", s, {bus.core_req_done_o, bus.stkz_req_done_o}, {~exp_stkz, exp_stkz});
            end
            if (bus.lsu_addr_o === SADDR && first_stkz == 0) first_stkz = s;
            if (bus.core_resp_valid_o || bus.stkz_resp_valid_o) begin
                vecs++;
                if (exp_q.size() == 0) begin
                    miscmp++; $display("FAIL fair_resp_s%0d: got %b want no response", s, resp_obs());
                end else begin
                    e = exp_q.pop_front();
                    if (resp_obs() !== exp_obs(e)) begin miscmp++; $display("FAIL fair_resp_s%0d: got %b want %b", s, resp_obs(), exp_obs(e)); end
                end
            end
        end
        @(negedge clk_i);
        set_in(0, 0, 0, 0, 0);
        vecs++;
        if (first_stkz != want_first) begin miscmp++; $display("FAIL fair_first_stkz_slot: got %0d want %0d", first_stkz, want_first); end
        vecs++;
        if (exp_q.size() != 0) begin miscmp++; $display("FAIL fair_missing_resp: got %0d pending want 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        @(negedge clk_i);
        set_in(1, 0, 1, 0, 0);
        exp_q.push_back('{stkz: 1'b0, err: 1'b0});
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk_i);
            set_in(0, 1, 0, 0, 0);
            #1;
            vecs++;
            if (lsu_bus() !== STKZ_BUS) begin miscmp++; $display("FAIL rmid_stkz_c%0d: got %h want %h", c, lsu_bus(), STKZ_BUS); end
        end
        @(negedge clk_i);
        rst_ni = 1'b0;
        set_in(0, 0, 0, 0, 0);
        exp_q.delete();
        #1;
        vecs++;
        if (all_outs() !== '0) begin miscmp++; $display("FAIL rmid_async_outs: got %h want 0", all_outs()); end
        @(posedge clk_i);
        #1;
        vecs++;
        if (all_outs() !== '0) begin miscmp++; $display("FAIL rmid_edge_outs: got %h want 0", all_outs()); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            set_in(c == 0, c == 1, c <= 1, c <= 1, 1'b0);
            #1;
            if (c <= 1) begin
                exp_q.push_back('{stkz: (c == 1), err: 1'b0});
                vecs++;
                if (lsu_bus() !== (c == 1 ? STKZ_BUS : CORE_BUS)) begin
                    miscmp++; $display("FAIL rmid_after_c%0d: got %h want %h", c, lsu_bus(), c == 1 ? STKZ_BUS : CORE_BUS);
                end
            end
            if (bus.core_resp_valid_o || bus.stkz_resp_valid_o) begin
                vecs++;
                if (exp_q.size() == 0) begin
                    miscmp++; $display("FAIL rmid_resp_c%0d: got %b want no response", c, resp_obs());
                end else begin
                    e = exp_q.pop_front();
                    if (resp_obs() !== exp_obs(e)) begin miscmp++; $display("FAIL rmid_resp_c%0d: got %b want %b", c, resp_obs(), exp_obs(e)); end
                end
            end
        end
        vecs++;
        if (exp_q.size() != 0) begin miscmp++; $display("FAIL rmid_missing_resp: got %0d pending want 0", exp_q.size()); exp_q.delete(); end
    endtask

    initial begin
        bus.core_we_i     = 1'b0;
        bus.core_is_cap_i = 1'b0;
        bus.core_addr_i   = CADDR;
        bus.core_wdata_i  = CWD;
        bus.stkz_we_i     = 1'b1;
        bus.stkz_is_cap_i = 1'b1;
        bus.stkz_addr_i   = SADDR;
        bus.stkz_wdata_i  = SWD;
        set_in(0, 0, 0, 0, 0);

        test_reset();
        test_priority();
        test_err_route();
        test_outstanding();
        test_fairness();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
        $finish;
    end

endmodule

// File: doc/cheri_stkz_lsu_arb.md
CHERI_STKZ_LSU_ARB -- requirements
Module: cheri_stkz_lsu_arb

Interface
REQ-001 Parameter DataWidth, default 33, LSU raw write-data width; legal values 32, 33, 65.
REQ-002 clk_i  input  1  clock.
REQ-003 rst_ni  input  1  reset; asynchronous, active-low.
REQ-004 core_req_i, core_we_i, core_is_cap_i  input  1 each  core LSU request, write enable, capability access.
REQ-005 core_addr_i  input  32  core request address.
REQ-006 core_wdata_i  input  DataWidth  core raw write data.
REQ-007 core_req_done_o, core_resp_valid_o, core_resp_err_o  output  1 each  routed completion, response valid, response error.
REQ-008 stkz_req_i, stkz_we_i, stkz_is_cap_i  input  1 each  zeroizer request, write enable, capability access.
REQ-009 stkz_addr_i  input  32  zeroizer request address.
REQ-010 stkz_wdata_i  input  DataWidth  zeroizer raw write data.
REQ-011 stkz_req_done_o, stkz_resp_valid_o, stkz_resp_err_o  output  1 each  routed completion, response valid, response error.
REQ-012 lsu_req_o, lsu_we_o, lsu_is_cap_o  output  1 each  merged LSU request, write enable, capability access.
REQ-013 lsu_addr_o  output  32  merged LSU address.
REQ-014 lsu_wdata_o  output  DataWidth  merged LSU raw write data.
REQ-015 lsu_req_done_i, lsu_resp_valid_i, lsu_resp_err_i  input  1 each  LSU request accepted, response valid, response error.

Function
REQ-016 FSM states: ARB_IDLE, ARB_CORE, ARB_STKZ; the owner is the FSM state when it is not ARB_IDLE, else the combinational arbitration pick.
REQ-017 ARB_IDLE pick: core if core_req_i, else stkz if stkz_req_i, else none; zero-latency: lsu_req_o asserts in the same cycle as the request.
REQ-018 lsu_req_o/we/is_cap/addr/wdata come from the owner's inputs; lsu_req_o = 0 when there is no owner.
REQ-019 ARB_IDLE -> ARB_CORE/ARB_STKZ when lsu_req_o=1 and lsu_req_done_i=0; the FSM stays in ARB_IDLE when done arrives in the same cycle.
REQ-020 ARB_CORE/ARB_STKZ -> ARB_IDLE on lsu_req_done_i; no owner switch mid-request; the requester holds its req until done.
REQ-021 lsu_req_done_i is routed only to the owner's *_req_done_o; the other *_req_done_o stays 0.
REQ-022 Each lsu_req_done_i pushes the owner into a 2-entry owner FIFO; each lsu_resp_valid_i pops it, routing resp_valid/resp_err to the head owner only.
REQ-023 Simultaneous push and pop on a non-empty FIFO leaves the count unchanged; on an empty FIFO the response goes to the pushing owner (bypass).
REQ-024 FIFO full (count 2) without lsu_resp_valid_i: no new grant in ARB_IDLE; lsu_req_o = 0.
REQ-025 lsu_resp_valid_i with an empty FIFO and no push is illegal: assertion fires and the response is dropped.

Reset
REQ-026 Reset forces ARB_IDLE, an empty FIFO and a zero fairness counter; with all requests low, every output is 0.
REQ-027 Reset mid-operation discards outstanding ownership; late LSU responses after reset fall under REQ-025.

Configuration
REQ-028 Macro CHERI_STKZ_ARB_FAIR_EN defined: a 3-bit counter increments on each core grant while stkz_req_i=1 and clears on a stkz grant or when stkz_req_i=0.
REQ-029 Under CHERI_STKZ_ARB_FAIR_EN, when the counter reaches 7, the next ARB_IDLE pick is stkz even if core_req_i=1.
REQ-030 Macro undefined: strict core priority; the counter is not built.

Structure
REQ-031 cheri_pkg holds arb_owner_t {OWN_CORE, OWN_STKZ}, the FSM enum and ARB_FAIR_LIMIT = 7.
REQ-032 The owner FIFO is sub-module cheri_lsu_owner_fifo (depth 2, push/pop/head/count).

Verification
REQ-033 core_req_i and stkz_req_i rise together; done on cycle 2 -> core granted first; stkz granted on cycle 3; one done pulse per side.
REQ-034 stkz request to 0x8000_0FF8, done in cycle 0, response err=1 on cycle 2 -> stkz_resp_err_o=1 on cycle 2; core_resp_valid_o stays 0.
REQ-035 Two dones (core then stkz) before any response; responses on cycles 5 and 6 -> routed core then stkz; third request blocked until cycle 5.
REQ-036 With FAIR_EN: continuous core_req_i and stkz_req_i, single-cycle dones -> stkz granted on the 8th grant slot; without FAIR_EN -> stkz never granted.
REQ-037 rst_ni asserted while in ARB_STKZ with 1 outstanding response -> ARB_IDLE, FIFO empty, all outputs 0 next edge.
